antilog: RTL
============

ANTILOG -- requirements
Module: antilog

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the width of number_i and number_o.
REQ-002 The block SHALL have parameter FRAC_BITS, default 5, the number of fractional bits of number_i (LSB = 0.03125).
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 valid_i  input  1  number_i valid.
REQ-007 ready_o  output  1  block can accept an operand.
REQ-008 number_i  input  DATA_WIDTH  log2 value, unsigned fixed point, integer part k = number_i[7:5], fraction f = number_i[4:0].
REQ-009 valid_o  output  1  number_o holds a new result.
REQ-010 ready_i  input  1  downstream accepts the result.
REQ-011 number_o  output  DATA_WIDTH  unsigned integer round(2^(number_i/32)).

Function
REQ-012 The block SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-013 ready_o SHALL be 1 only in IDLE; an operand is accepted on an edge where valid_i && ready_o, number_i captured, IDLE -> LOAD.
REQ-014 In IDLE with valid_i=0, state and outputs SHALL hold.
REQ-015 LOAD SHALL load a 16-bit accumulator with LUT[f] = round(256 * 2^(f/32)), f = 0..31, 9-bit values 256..501, load counter cnt = k, then -> SHIFT.
REQ-016 SHIFT with cnt != 0 SHALL shift the accumulator left by one and decrement cnt, one bit per cycle.
REQ-017 SHIFT with cnt == 0 SHALL register number_o = (acc + 128) >> 8, saturated to 2^DATA_WIDTH-1, set valid_o = 1, -> DONE.
REQ-018 Latency SHALL be k+2 cycles from the accept edge to the edge that raises valid_o: 2 for k=0, 9 for k=7.
REQ-019 In DONE, valid_o and number_o SHALL hold stable while ready_i = 0.
REQ-020 In DONE with ready_i = 1, the next edge SHALL clear valid_o and go to IDLE; ready_o rises on that same edge.
REQ-021 number_o SHALL keep the last result after valid_o falls, until the next result is written.
REQ-022 valid_i and number_i changes outside IDLE SHALL be ignored; no operand is queued.
REQ-023 The maximum result (number_i = 0xFF) SHALL be 251, so saturation never triggers at default parameters but SHALL still be implemented.

Reset
REQ-024 While rst_i = 1 at an edge, state SHALL become IDLE, valid_o = 0, number_o = 0, accumulator and cnt = 0; ready_o = 1 in the cycle after reset.
REQ-025 Reset asserted in LOAD, SHIFT or DONE SHALL abort the operation with no valid_o pulse; the discarded result SHALL never appear.

Verification
REQ-026 Reset mid-SHIFT (number_i=0xE0, rst_i at 4th cycle after accept) -> valid_o stays 0, number_o = 0, ready_o = 1 next cycle.
REQ-027 number_i = 0x00 with ready_i = 1 -> number_o = 1, valid_o high 2 cycles after accept, for exactly 1 cycle.
REQ-028 number_i = 0x20 -> 2 at latency 3; 0xA0 -> 32 at latency 7; 0x10 -> 1; 0xE0 -> 128 at latency 9.
REQ-029 number_i = 0xFF -> number_o = 251, valid_o at latency 9.
REQ-030 Backpressure: 0x60 accepted, ready_i = 0 for 5 cycles -> valid_o = 1 and number_o = 8 stable throughout, ready_o = 0, a new valid_i ignored; ready_i = 1 -> IDLE next edge.
REQ-031 Sweep number_i 0..255 back-to-back -> every number_o within 1 LSB of round(2^(number_i/32)) from a bench reference model; count and report maximum absolute error.

Source files
------------

// File: rtl/antilog.sv
// antilog: sequential base-2 antilogarithm.
//
// Converts an unsigned fixed-point log2 value into round(2^(number_i/32)).
// The integer part k selects a left-shift count and the fractional part f
// indexes a 32-entry table of 256 * 2^(f/32). The table entry is loaded
// into an accumulator and shifted left one bit per cycle, k times. The
// result is then rounded back to an integer.
//
// Latency is k+2 cycles from the accept edge to the edge that raises
// valid_o. The result is held under downstream backpressure.
//
// Ports
//   clk_i     in   1           clock, rising edge
//   rst_i     in   1           synchronous active-high reset
//   valid_i   in   1           number_i valid
//   ready_o   out  1           block can accept an operand (IDLE only)
//   number_i  in   DATA_WIDTH  log2 value, k = [DW-1:FRAC_BITS], f = [FRAC_BITS-1:0]
//   valid_o   out  1           number_o holds a new result
//   ready_i   in   1           downstream accepts the result
//   number_o  out  DATA_WIDTH  round(2^(number_i/2^FRAC_BITS)), saturated
module antilog #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] number_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] number_o
);

    localparam int INT_BITS = DATA_WIDTH - FRAC_BITS;
    localparam int ACC_W    = 16;
    localparam int LUT_W    = 9;

    // Largest representable output, widened to the rounding width
    localparam logic [ACC_W:0] MAX_OUT = (ACC_W+1)'((1 << DATA_WIDTH) - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] operand;
    logic [ACC_W-1:0]      acc;
    logic [INT_BITS-1:0]   cnt;

    // round(256 * 2^(f/32)) for f = 0..31
    function automatic logic [LUT_W-1:0] frac_lut(input logic [4:0] f);
        logic [LUT_W-1:0] v;
        case (f)
            5'd0:    v = 9'd256;
            5'd1:    v = 9'd262;
            5'd2:    v = 9'd267;
            5'd3:    v = 9'd273;
            5'd4:    v = 9'd279;
            5'd5:    v = 9'd285;
            5'd6:    v = 9'd292;
            5'd7:    v = 9'd298;
            5'd8:    v = 9'd304;
            5'd9:    v = 9'd311;
            5'd10:   v = 9'd318;
            5'd11:   v = 9'd325;
            5'd12:   v = 9'd332;
            5'd13:   v = 9'd339;
            5'd14:   v = 9'd347;
            5'd15:   v = 9'd354;
            5'd16:   v = 9'd362;
            5'd17:   v = 9'd370;
            5'd18:   v = 9'd378;
            5'd19:   v = 9'd386;
            5'd20:   v = 9'd395;
            5'd21:   v = 9'd403;
            5'd22:   v = 9'd412;
            5'd23:   v = 9'd421;
            5'd24:   v = 9'd431;
            5'd25:   v = 9'd440;
            5'd26:   v = 9'd450;
            5'd27:   v = 9'd459;
            5'd28:   v = 9'd470;
            5'd29:   v = 9'd480;
            5'd30:   v = 9'd490;
            default: v = 9'd501;
        endcase
        return v;
    endfunction

    // Drop the 8 table fraction bits with round-half-up, then clamp to the
    // output range. The clamp cannot engage at the default widths
    // (max 501 << 7 rounds to 251), but it protects other parameterisations.
    function automatic logic [DATA_WIDTH-1:0] round_sat(input logic [ACC_W-1:0] a);
        logic [ACC_W:0] r;
        r = ({1'b0, a} + (ACC_W+1)'(128)) >> 8;
        if (r > MAX_OUT) begin
            return {DATA_WIDTH{1'b1}};
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            number_o <= '0;
            operand  <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // ready_o is high throughout IDLE, so valid_i alone
                    // marks the handshake
                    if (valid_i) begin
                        operand <= number_i;
                        ready_o <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    acc   <= {{(ACC_W-LUT_W){1'b0}}, frac_lut(operand[FRAC_BITS-1:0])};
                    cnt   <= operand[DATA_WIDTH-1:FRAC_BITS];
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        acc <= acc << 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        number_o <= round_sat(acc);
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
